// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump sequencer.
// Imported by the dump unit; the bench uses the same state names for readability only.
package reg_dump_pkg;

   localparam int DUMP_CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_READ   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_SEND   = 3'd4
   } state_t;

endpackage

// File: rtl/reg_dump_if.sv
// Register-file read port plus valid/ready output stream of the dump unit.
// master = dump unit side, slave = register file / stream sink side.
interface reg_dump_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8
);
   localparam int ADDR_W = $clog2(NUM_REGS);

   logic              rf_rd_en;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_rdata;

   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output rf_rd_en, rf_addr, out_data, out_valid, out_last,
      input  rf_rdata, out_ready
   );

   modport slave (
      input  rf_rd_en, rf_addr, out_data, out_valid, out_last,
      output rf_rdata, out_ready
   );
endinterface

// File: rtl/reg_dump_unit.sv
// Walks the register file on a halt edge or dump request and streams an optional
// header word (register count) followed by every register word over valid/ready.
module reg_dump_unit
   import reg_dump_pkg::*;
#(
   parameter int   DATA_W      = 8,
   parameter int   NUM_REGS    = 8,
   parameter bit   EMIT_HEADER = 1'b1,
   localparam int  ADDR_W      = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  halt,
   input  logic                  dump_req,
   reg_dump_if.master            bus,
   output logic                  busy,
   output logic [DUMP_CNT_W-1:0] dump_count
);

   localparam logic [DATA_W-1:0] HDR_WORD = DATA_W'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       idx_q, idx_d;
   logic                    pending_q, pending_d;
   logic                    halt_q, halt_d;
   logic                    rf_rd_en_q, rf_rd_en_d;
   logic [ADDR_W-1:0]       rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0]       out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    busy_q, busy_d;
   logic [DUMP_CNT_W-1:0]   dump_count_q, dump_count_d;
   logic                    trigger;

   always_comb begin
      trigger      = (halt & ~halt_q) | dump_req;
      halt_d       = halt;
      state_d      = state_q;
      idx_d        = idx_q;
      pending_d    = pending_q;
      rf_rd_en_d   = 1'b0;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      dump_count_d = dump_count_q;

      case (state_q)
         ST_IDLE: begin
            if (trigger || pending_q) begin
               pending_d = 1'b0;
               idx_d     = '0;
               if (EMIT_HEADER) begin
                  state_d     = ST_HEADER;
                  out_valid_d = 1'b1;
                  out_data_d  = HDR_WORD;
                  out_last_d  = 1'b0;
               end else begin
                  state_d    = ST_READ;
                  rf_rd_en_d = 1'b1;
               end
            end
         end
         ST_HEADER: begin
            if (bus.out_ready) begin
               state_d     = ST_READ;
               out_valid_d = 1'b0;
               rf_rd_en_d  = 1'b1;
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Read data returns one cycle after the strobe; capture it straight into the stream register.
            out_data_d  = bus.rf_rdata;
            out_valid_d = 1'b1;
            out_last_d  = (idx_q == LAST_IDX);
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (idx_q == LAST_IDX) begin
                  dump_count_d = dump_count_q + DUMP_CNT_W'(1);
                  state_d      = ST_IDLE;
               end else begin
                  idx_d      = idx_q + ADDR_W'(1);
                  state_d    = ST_READ;
                  rf_rd_en_d = 1'b1;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase

      // A trigger arriving mid-dump (including on the final handshake) is remembered, one deep.
      if (state_q != ST_IDLE && trigger) begin
         pending_d = 1'b1;
      end

      rf_addr_d = idx_d;
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         pending_q    <= 1'b0;
         halt_q       <= 1'b1;
         rf_rd_en_q   <= 1'b0;
         rf_addr_q    <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         dump_count_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         halt_q       <= halt_d;
         rf_rd_en_q   <= rf_rd_en_d;
         rf_addr_q    <= rf_addr_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
         dump_count_q <= dump_count_d;
      end
   end

   assign bus.rf_rd_en  = rf_rd_en_q;
   assign bus.rf_addr   = rf_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;
   assign dump_count    = dump_count_q;

   hold_while_stalled: assert property (@(posedge clk) disable iff (!reset)
      (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));

   rd_only_in_read: assert property (@(posedge clk)
      bus.rf_rd_en |-> (state_q == ST_READ));

endmodule

// File: tb/tb_reg_dump_unit.sv
// Randomised bench for reg_dump_unit: a transaction-level model of the dump protocol
// is checked every cycle, plus literal expectations for the directed scenarios.
module tb_reg_dump_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        halt0, req0, halt1, req1;
   logic        busy0, busy1;
   logic [15:0] cnt0, cnt1;
   bit          rnd_rdy0, rnd_rdy1;
   int          cyc = 0;

   reg_dump_if #(.DATA_W(8),  .NUM_REGS(8)) bus0 ();
   reg_dump_if #(.DATA_W(16), .NUM_REGS(4)) bus1 ();

   reg_dump_unit #(.DATA_W(8), .NUM_REGS(8), .EMIT_HEADER(1'b1)) dut0 (
      .clk(clk), .reset(reset), .halt(halt0), .dump_req(req0),
      .bus(bus0), .busy(busy0), .dump_count(cnt0));

   reg_dump_unit #(.DATA_W(16), .NUM_REGS(4), .EMIT_HEADER(1'b0)) dut1 (
      .clk(clk), .reset(reset), .halt(halt1), .dump_req(req1),
      .bus(bus1), .busy(busy1), .dump_count(cnt1));

   // Behavioural register files with one-cycle registered read.
   logic [7:0]  rf0 [8];
   logic [15:0] rf1 [4];
   always @(posedge clk) if (bus0.rf_rd_en) bus0.rf_rdata <= rf0[bus0.rf_addr];
   always @(posedge clk) if (bus1.rf_rd_en) bus1.rf_rdata <= rf1[bus1.rf_addr];
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Expected word p of a dump: header carries the register count, then rf[0..N-1].
   function automatic longint exp_word(input int u, input int p);
      if (u == 0) return (p == 0) ? 64'd8 : longint'(rf0[p-1]);
      return longint'(rf1[p]);
   endfunction

   // Transaction-level model state, one entry per DUT.
   bit          m_active [2];
   bit          m_pend   [2];
   int          m_pos    [2];
   logic [15:0] m_cnt    [2];
   bit          m_hprev  [2];
   bit          m_stall  [2];
   bit          m_rdone  [2];
   bit          model_valid = 1'b0;

   logic [15:0] log_d0[$];
   bit          log_l0[$];
   int          log_c0[$];
   logic [15:0] log_d1[$];
   bit          log_l1[$];
   int          log_a1[$];
   int          busy_n0 = 0;

   always @(negedge clk) begin
      logic v, rdy, lst, rd, bz, h, rq, trig, hs;
      logic [15:0] d, c;
      int addr, hdr, nw;
      for (int u = 0; u < 2; u++) begin
         if (u == 0) begin
            v = bus0.out_valid; rdy = bus0.out_ready; lst = bus0.out_last; rd = bus0.rf_rd_en;
            d = 16'(bus0.out_data); addr = int'(bus0.rf_addr); bz = busy0; c = cnt0;
            h = halt0; rq = req0; hdr = 1; nw = 9;
         end else begin
            v = bus1.out_valid; rdy = bus1.out_ready; lst = bus1.out_last; rd = bus1.rf_rd_en;
            d = bus1.out_data; addr = int'(bus1.rf_addr); bz = busy1; c = cnt1;
            h = halt1; rq = req1; hdr = 0; nw = 4;
         end

         if (model_valid) begin
            chk("busy", bz, m_active[u]);
            chk("dump_count", c, m_cnt[u]);
            if (m_stall[u]) chk("valid_held", v, 1);
            if (!m_active[u]) begin
               chk("valid_when_idle", v, 0);
               chk("rd_when_idle", rd, 0);
            end else begin
               if (v) begin
                  chk("out_data", d, exp_word(u, m_pos[u]));
                  chk("out_last", lst, (m_pos[u] == nw - 1));
                  if (!(hdr == 1 && m_pos[u] == 0)) chk("read_before_word", m_rdone[u], 1);
               end
               if (rd) begin
                  chk("rf_addr", addr, m_pos[u] - hdr);
                  chk("read_once", m_rdone[u], 0);
                  chk("rd_while_valid", v, 0);
               end
            end
         end

         if (reset) begin
            if (u == 0 && bz) busy_n0++;
            if (v && rdy) begin
               if (u == 0) begin log_d0.push_back(d); log_l0.push_back(lst); log_c0.push_back(cyc + 1); end
               else begin log_d1.push_back(d); log_l1.push_back(lst); end
            end
            if (u == 1 && rd) log_a1.push_back(addr);
         end

         // Advance the model to what must hold after the coming rising edge.
         if (!reset) begin
            m_active[u] = 0; m_pend[u] = 0; m_pos[u] = 0; m_cnt[u] = '0;
            m_hprev[u] = 1; m_stall[u] = 0; m_rdone[u] = 0;
            model_valid = 1'b1;
         end else begin
            trig = (h && !m_hprev[u]) || rq;
            m_hprev[u] = h;
            hs = v && rdy;
            m_stall[u] = v && !rdy;
            if (rd) m_rdone[u] = 1;
            if (m_active[u]) begin
               if (trig) m_pend[u] = 1;
               if (hs) begin
                  m_rdone[u] = 0;
                  if (m_pos[u] == nw - 1) begin
                     m_active[u] = 0; m_pos[u] = 0; m_cnt[u] = m_cnt[u] + 16'd1;
                  end else begin
                     m_pos[u] = m_pos[u] + 1;
                  end
               end
            end else if (trig || m_pend[u]) begin
               m_active[u] = 1; m_pend[u] = 0; m_pos[u] = 0; m_rdone[u] = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         bus0.out_ready = rnd_rdy0 ? 1'($urandom_range(0, 1)) : 1'b1;
         bus1.out_ready = rnd_rdy1 ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle(input int u, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (((u == 0) ? busy0 : busy1) == 1'b0) break;
         tick(1);
      end
      chk("idle_within_budget", (k < budget), 1);
   endtask

   task automatic pulse_req0();
      req0 = 1'b1; tick(1); req0 = 1'b0;
   endtask

   initial begin
      int base, bbase, n_trig, k, idle_n;
      logic [15:0] base_c;
      logic [15:0] rf1_lit [4];

      for (int i = 0; i < 8; i++) rf0[i] = 8'h10 + 8'(i);
      rf1_lit[0] = 16'hBEEF; rf1_lit[1] = 16'h1234; rf1_lit[2] = 16'h0F0F; rf1_lit[3] = 16'h8001;
      for (int i = 0; i < 4; i++) rf1[i] = rf1_lit[i];
      for (int u = 0; u < 2; u++) m_hprev[u] = 1;
      reset = 1'b0; halt0 = 1'b0; req0 = 1'b0; halt1 = 1'b0; req1 = 1'b0;
      rnd_rdy0 = 1'b0; rnd_rdy1 = 1'b0;
      bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
      tick(3);
      chk("reset_valid", bus0.out_valid, 0);
      chk("reset_busy", busy0, 0);
      chk("reset_count", cnt0, 0);
      chk("reset_rd_en", bus0.rf_rd_en, 0);
      reset = 1'b1;
      tick(2);

      // Halt rising edge, ready tied high: exact stream, timing and busy length.
      base = log_d0.size(); bbase = busy_n0;
      halt0 = 1'b1; n_trig = cyc + 1;
      tick(1);
      wait_idle(0, 100);
      chk("p1_words", log_d0.size() - base, 9);
      for (int j = 0; j < 9 && base + j < log_d0.size(); j++) begin
         chk("p1_word", log_d0[base+j], (j == 0) ? 8'h08 : 8'h0F + j);
         chk("p1_last", log_l0[base+j], (j == 8));
         chk("p1_edge", log_c0[base+j] - n_trig, 3*j + 1);
      end
      chk("p1_count", cnt0, 1);
      chk("p1_busy_cycles", busy_n0 - bbase, 25);

      // Second configuration: no header, 16-bit words, random back-pressure.
      rnd_rdy1 = 1'b1;
      halt1 = 1'b1;
      tick(1);
      wait_idle(1, 200);
      rnd_rdy1 = 1'b0;
      chk("p6_words", log_d1.size(), 4);
      chk("p6_reads", log_a1.size(), 4);
      for (int j = 0; j < 4 && j < log_d1.size(); j++) begin
         chk("p6_word", log_d1[j], rf1_lit[j]);
         chk("p6_last", log_l1[j], (j == 3));
      end
      for (int j = 0; j < 4 && j < log_a1.size(); j++) chk("p6_addr", log_a1[j], j);
      chk("p6_count", cnt1, 1);

      // Random back-pressure on the default instance.
      base = log_d0.size();
      rnd_rdy0 = 1'b1;
      pulse_req0();
      wait_idle(0, 500);
      rnd_rdy0 = 1'b0;
      tick(1);
      chk("p2_words", log_d0.size() - base, 9);
      for (int j = 0; j < 9 && base + j < log_d0.size(); j++)
         chk("p2_word", log_d0[base+j], (j == 0) ? 8'h08 : 8'h0F + j);
      chk("p2_count", cnt0, 2);

      // Triggers while busy merge into a single follow-on dump after one idle cycle.
      base_c = cnt0;
      pulse_req0();
      tick(6); pulse_req0();
      tick(3); pulse_req0();
      tick(2); pulse_req0();
      idle_n = 0;
      for (k = 0; k < 200; k++) begin
         tick(1);
         if (cnt0 == base_c + 16'd2) break;
         if (!busy0) idle_n++;
      end
      chk("p3_two_dumps", 16'(cnt0 - base_c), 2);
      chk("p3_idle_gap", idle_n, 1);
      tick(40);
      chk("p3_no_third", 16'(cnt0 - base_c), 2);

      // Reset in the middle of a dump, then restart from a fresh halt edge.
      pulse_req0();
      for (k = 0; k < 100; k++) begin
         if (bus0.out_valid && bus0.out_data == 8'h14) break;
         tick(1);
      end
      chk("p4_reached_reg4", (k < 100), 1);
      reset = 1'b0;
      tick(1);
      chk("p4_valid", bus0.out_valid, 0);
      chk("p4_data", bus0.out_data, 0);
      chk("p4_last", bus0.out_last, 0);
      chk("p4_busy", busy0, 0);
      chk("p4_count", cnt0, 0);
      reset = 1'b1;
      tick(2);
      halt0 = 1'b0; tick(2);
      base = log_d0.size();
      halt0 = 1'b1; tick(1);
      wait_idle(0, 100);
      chk("p4_restart_words", log_d0.size() - base, 9);
      if (log_d0.size() > base) chk("p4_restart_header", log_d0[base], 8'h08);
      chk("p4_restart_count", cnt0, 1);

      // Halt held high across reset release must not start a dump.
      reset = 1'b0; tick(2);
      reset = 1'b1; tick(10);
      chk("p5_no_dump_busy", busy0, 0);
      chk("p5_no_dump_count", cnt0, 0);
      halt0 = 1'b0; tick(2);
      halt0 = 1'b1; tick(1);
      wait_idle(0, 100);
      chk("p5_one_dump", cnt0, 1);

      tick(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Synthesizable successor to the simulation-only halt register dump.
- When the CPU halts, or on an explicit request, walks the register file through a read port and streams a header word plus every register word over a valid/ready output channel.
- Parametrised in data width and register count; adds a handshake, back-pressure, a pending trigger and a dump counter.
- Sits beside the CPU register file inside computer, feeding the output-port logic.

Parameters:
- DATA_W, 8, register and output word width (>=4)
- NUM_REGS, 8, number of registers dumped, indices 0..NUM_REGS-1 (2..256)
- ADDR_W, $clog2(NUM_REGS), register file address width (derived, not overridden)
- EMIT_HEADER, 1, 1 = send header word before register words; 0 = registers only

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- halt  input  1  CPU halt level (c_halt)
- dump_req  input  1  single-cycle dump request
- rf_rd_en  output  1  register file read strobe
- rf_addr  output  ADDR_W  register file read address
- rf_rdata  input  DATA_W  read data, valid the cycle after rf_rd_en
- out_data  output  DATA_W  stream word
- out_valid  output  1  stream word valid
- out_ready  input  1  sink accepts the word
- out_last  output  1  marks the final register word
- busy  output  1  dump in progress
- dump_count  output  16  completed dumps, wraps 0xFFFF->0

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; every output 0; pending=0; idx=0.
  - halt_q=1, so a halt already high at reset release does not trigger.
- Trigger: (halt & ~halt_q) | dump_req. halt_q registers halt every cycle.
- States: IDLE, HEADER, READ, WAIT, SEND.
- IDLE:
  - On trigger or pending: clear pending; idx=0.
  - Go to HEADER if EMIT_HEADER, else READ.
- HEADER:
  - out_valid=1; out_data=NUM_REGS zero-extended/truncated to DATA_W; out_last=0.
  - On out_valid&out_ready go to READ.
- READ:
  - rf_rd_en=1, rf_addr=idx for exactly one cycle, then WAIT.
- WAIT:
  - On the edge, register rf_rdata into out_data.
  - Set out_valid=1, out_last=(idx==NUM_REGS-1); go to SEND.
- SEND:
  - Hold out_data, out_valid and out_last stable while out_ready==0.
  - On handshake: if idx==NUM_REGS-1, then out_valid=0, out_last=0, dump_count+=1, go to IDLE.
  - Otherwise idx+=1 and go to READ.
- Latency with out_ready tied high, trigger sampled at edge N:
  - Header valid after edge N.
  - Register k valid after edge N+3+3k.
  - Last handshake at edge N+3*NUM_REGS+1.
  - busy drops after that edge.
- busy = (state != IDLE).
- out_valid never drops without a handshake, except on reset.
- Trigger while busy sets pending (one deep; further triggers are merged). Pending starts the next dump on the cycle after return to IDLE, so there is one IDLE cycle between dumps.
- A trigger coinciding with the final handshake sets pending.
- Reset mid-dump aborts immediately: all outputs 0, pending cleared, dump_count=0.
- rf_rd_en is 0 in every state except READ; rf_addr holds idx.

Decomposition:
- Shared package reg_dump_pkg:
  - state enum localparams (IDLE..SEND, 3-bit encoding)
  - DUMP_CNT_W=16
- No sub-module is natural. Edge detection and the sequencer stay inline in reg_dump_unit.
- The bench's register file model is a behavioural array with 1-cycle registered read.

Test Plan:
- Defaults, rf[i]=8'h10+i, out_ready=1, halt 0->1:
  - stream 08,10,11,12,13,14,15,16,17
  - out_last only on 17
  - dump_count 0->1
  - busy for 25 cycles
- Back-pressure: out_ready toggled pseudo-randomly:
  - same 9 words, each held stable until accepted
  - no word lost or duplicated
- dump_req pulsed mid-dump, then pulsed twice more:
  - exactly one extra dump follows after one IDLE cycle
  - dump_count ends at 2
- reset=0 at register 4 of a dump:
  - next cycle outputs 0, busy 0, dump_count 0
  - new halt edge restarts the dump from the header
- halt held high through reset release:
  - no dump
  - halt fall then rise -> one dump
- NUM_REGS=4, DATA_W=16, EMIT_HEADER=0:
  - stream rf[0..3] only, out_last on the 4th word
  - rf_addr sequence 0,1,2,3
